led_pattern_core: RTL and testbench

- Design root of the FPGA template.
- Takes one board clock and one reset, and drives a 4-bit LED bank.
- An internal prescaler produces a periodic tick. On each tick a mode sequencer steps the LED pattern.
- Modes rotate automatically: COUNT -> SWEEP -> BLINK -> COUNT.

---
 rtl/led_pattern_pkg.sv | 43 ++++
 rtl/led_pattern_core_tick_gen.sv | 37 +++
 rtl/led_pattern_core.sv | 131 +++++++++++++
 tb/tb_led_pattern_core.sv | 107 ++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_pkg
// Purpose  : Shared types and constants for the LED pattern core: the mode
//            enumeration, the entry pattern of each mode, the LED bank width
//            and helpers for mode rotation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SWEEP = 2'd1,
        MODE_BLINK = 2'd2
    } mode_e;

    localparam logic [LED_W-1:0] PAT_COUNT_INIT = 4'b0000;
    localparam logic [LED_W-1:0] PAT_SWEEP_INIT = 4'b0001;
    localparam logic [LED_W-1:0] PAT_BLINK_INIT = 4'b1111;

    // Rotation COUNT -> SWEEP -> BLINK -> COUNT; the unused encoding
    // falls back to COUNT so a corrupted mode register recovers.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_COUNT: next_mode = MODE_SWEEP;
            MODE_SWEEP: next_mode = MODE_BLINK;
            default:    next_mode = MODE_COUNT;
        endcase
    endfunction

    function automatic logic [LED_W-1:0] entry_pattern(input mode_e m);
        case (m)
            MODE_SWEEP: entry_pattern = PAT_SWEEP_INIT;
            MODE_BLINK: entry_pattern = PAT_BLINK_INIT;
            default:    entry_pattern = PAT_COUNT_INIT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_core_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Prescaler. Counts 0..DIV-1 and wraps; tick is decoded
//            combinationally from the count register on its last value.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous active-high reset
//            tick - one-cycle strobe, high while count == DIV-1
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_pcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (r_pcnt == c_last) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    assign tick = (r_pcnt == c_last);

endmodule
`default_nettype wire

// File: rtl/led_pattern_core.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_core
// Purpose  : FPGA template root. A prescaler tick steps a mode sequencer
//            that drives a 4-bit LED bank; modes rotate COUNT -> SWEEP ->
//            BLINK every MODE_TICKS ticks.
//            Optional macro LED_HEARTBEAT_EN: led[3] becomes a heartbeat
//            flop toggling every MODE_TICKS/2 ticks.
// Ports    : clk - system clock, rising edge
//            rst - synchronous active-high reset
//            led - registered LED drive, 1 = on
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_core
    import led_pattern_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int MODE_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [LED_W-1:0] led
);

    localparam int               MT_W       = (MODE_TICKS > 1) ? $clog2(MODE_TICKS) : 1;
    localparam logic [MT_W-1:0]  c_mt_last  = MT_W'(MODE_TICKS - 1);
    localparam logic [LED_W-1:0] c_sweep_hi = 4'b1000;
    localparam logic [LED_W-1:0] c_sweep_lo = 4'b0001;

    logic             w_tick;

    mode_e            r_mode,   w_mode_nxt;
    logic [MT_W-1:0]  r_mtcnt,  w_mtcnt_nxt;
    logic [LED_W-1:0] r_pat,    w_pat_nxt;
    logic             r_dir_up, w_dir_up_nxt;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= MODE_COUNT;
            r_mtcnt  <= '0;
            r_pat    <= PAT_COUNT_INIT;
            r_dir_up <= 1'b1;
        end else begin
            r_mode   <= w_mode_nxt;
            r_mtcnt  <= w_mtcnt_nxt;
            r_pat    <= w_pat_nxt;
            r_dir_up <= w_dir_up_nxt;
        end
    end

    always_comb begin
        w_mode_nxt   = r_mode;
        w_mtcnt_nxt  = r_mtcnt;
        w_pat_nxt    = r_pat;
        w_dir_up_nxt = r_dir_up;
        if (w_tick) begin
            if (r_mtcnt == c_mt_last) begin
                // Mode boundary: load the new mode's entry pattern instead of stepping.
                w_mtcnt_nxt  = '0;
                w_mode_nxt   = next_mode(r_mode);
                w_pat_nxt    = entry_pattern(next_mode(r_mode));
                w_dir_up_nxt = 1'b1;
            end else begin
                w_mtcnt_nxt = r_mtcnt + 1'b1;
                case (r_mode)
                    MODE_COUNT: w_pat_nxt = r_pat + 1'b1;
                    MODE_SWEEP: begin
                        // Bounce: reverse at the end bits and take the step
                        // away from the end on the same tick.
                        if (r_dir_up) begin
                            if (r_pat == c_sweep_hi) begin
                                w_pat_nxt    = r_pat >> 1;
                                w_dir_up_nxt = 1'b0;
                            end else begin
                                w_pat_nxt    = r_pat << 1;
                            end
                        end else begin
                            if (r_pat == c_sweep_lo) begin
                                w_pat_nxt    = r_pat << 1;
                                w_dir_up_nxt = 1'b1;
                            end else begin
                                w_pat_nxt    = r_pat >> 1;
                            end
                        end
                    end
                    MODE_BLINK: w_pat_nxt = ~r_pat;
                    default:    w_pat_nxt = r_pat;
                endcase
            end
        end
    end

`ifdef LED_HEARTBEAT_EN
    localparam int               HB_HALF    = MODE_TICKS / 2;
    localparam int               HB_W       = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
    localparam logic [HB_W-1:0]  c_hb_last  = HB_W'(HB_HALF - 1);

    logic [HB_W-1:0] r_hb_cnt;
    logic            r_hb;

    // Independent tick counter so the heartbeat period stays exact even
    // when MODE_TICKS is odd.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else if (w_tick) begin
            if (r_hb_cnt == c_hb_last) begin
                r_hb_cnt <= '0;
                r_hb     <= ~r_hb;
            end else begin
                r_hb_cnt <= r_hb_cnt + 1'b1;
            end
        end
    end

    assign led = {r_hb, r_pat[LED_W-2:0]};
`else
    assign led = r_pat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_core
// Purpose  : Self-checking bench for led_pattern_core. Expected LED values
//            come from a closed-form model: count ticks since reset, derive
//            mode and position within the mode, and look the pattern up.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_core;

    localparam int TICK_DIV   = 4;
    localparam int MODE_TICKS = 16;

    logic       clk;
    logic       rst;
    logic [3:0] led;

    int n_checks   = 0;
    int n_failures = 0;

    // Model state: edges since reset release and ticks since reset release.
    int m_edges = 0;
    int m_ticks = 0;

    led_pattern_core #(
        .TICK_DIV   (TICK_DIV),
        .MODE_TICKS (MODE_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .led (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: observed %b expected %b (ticks=%0d)", tag, obs, exp, m_ticks);
        end
    endtask

    function automatic logic [3:0] model_led(input int t);
        int         mode;
        int         p;
        logic [3:0] v;
        int         sweep_seq [6] = '{1, 2, 4, 8, 4, 2};
        mode = (t / MODE_TICKS) % 3;
        p    = t % MODE_TICKS;
        case (mode)
            0:       v = 4'(p % 16);
            1:       v = 4'(sweep_seq[p % 6]);
            default: v = (p % 2 == 0) ? 4'b1111 : 4'b0000;
        endcase
`ifdef LED_HEARTBEAT_EN
        v[3] = ((t / (MODE_TICKS / 2)) % 2) == 1;
`endif
        return v;
    endfunction

    // Apply one clock edge with the given reset level, advance the model and
    // compare after the outputs have settled.
    task automatic step(input logic rst_v, input string tag);
        rst = rst_v;
        @(posedge clk);
        if (rst_v) begin
            m_edges = 0;
            m_ticks = 0;
        end else begin
            m_edges++;
            if (m_edges % TICK_DIV == 0) m_ticks++;
        end
        #1;
        check_eq(tag, led, model_led(m_ticks));
    endtask

    initial begin
        rst = 1'b1;

        // Reset held: LEDs stay dark, no tick effect.
        for (int i = 0; i < 10; i++) step(1'b1, "reset_hold");

        // Full rotation COUNT -> SWEEP -> BLINK -> COUNT and beyond.
        for (int i = 0; i < 200; i++) step(1'b0, "rotation");

        // Mid-run reset while in SWEEP (edge 70 after release).
        step(1'b1, "pre_sweep_reset");
        for (int i = 0; i < 69; i++) step(1'b0, "to_sweep");
        step(1'b1, "mid_reset");
        for (int i = 0; i < 100; i++) step(1'b0, "after_reset");

        // Random run with sporadic resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 149) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
